dmem_bypass_ram: RTL and testbench
==================================

DMEM_BYPASS_RAM -- requirements
Module: dmem_bypass_ram

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: word width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8: address width; depth = 2**ADDR_WIDTH.
REQ-003 The block SHALL have parameter NUM_WMASKS, default DATA_WIDTH/8: one mask bit per byte lane.
REQ-004 The block SHALL have parameter READ_LATENCY, default 1: cycles from read accept to rd_valid_o; legal values 1 or 2.
REQ-005 The block SHALL have parameter CLEAR_ON_RESET, default 1: 1 = zero the whole array after reset, 0 = skip clearing.
REQ-006 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-007 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous active-high reset.
- wr_en_i  in  1  write request.
- wr_addr_i  in  ADDR_WIDTH  write address.
- wr_mask_i  in  NUM_WMASKS  byte enables; bit k covers bits [8k+7:8k].
- wr_data_i  in  DATA_WIDTH  write data.
- rd_en_i  in  1  read request.
- rd_addr_i  in  ADDR_WIDTH  read address.
- ready_o  out  1  high when requests are accepted.
- rd_valid_o  out  1  one-cycle pulse marking rd_data_o valid.
- rd_data_o  out  DATA_WIDTH  read data.
- init_done_o  out  1  high once clearing is complete.

Function
REQ-008 The block SHALL implement a state machine with states CLEAR and RUN, leaving reset in CLEAR if CLEAR_ON_RESET=1 and in RUN otherwise.
REQ-009 In CLEAR, the block SHALL write zero to one address per cycle, from 0 to depth-1, then enter RUN in the following cycle; clearing takes depth cycles.
REQ-010 ready_o and init_done_o SHALL be 0 in CLEAR and 1 in RUN.
REQ-011 Requests presented while ready_o=0 SHALL be ignored; they are not queued.
REQ-012 A write SHALL be accepted when wr_en_i && ready_o, and SHALL update only the byte lanes whose mask bit is set, at posedge.
REQ-013 A write with wr_mask_i = 0 SHALL leave the array unchanged.
REQ-014 A read SHALL be accepted when rd_en_i && ready_o.
REQ-015 For a read accepted at cycle N, rd_valid_o SHALL be 1 and rd_data_o valid during cycle N+READ_LATENCY.
- Reads are fully pipelined: one read accepted per cycle.
- There is no output backpressure.
REQ-016 Read data SHALL reflect every write accepted in cycles up to and including N (write-first).
- A same-cycle, same-address write is forwarded per byte: masked lanes come from wr_data_i, other lanes from the array.
REQ-017 With READ_LATENCY=2, a write accepted in cycle N+1 to the in-flight read address SHALL NOT affect that read's data.
- The data is a snapshot at the end of cycle N.
REQ-018 rd_data_o SHALL hold its last valid value while rd_valid_o=0.
REQ-019 Simultaneous read and write to different addresses SHALL both complete with no interaction.
REQ-020 Addresses SHALL be used modulo depth; there is no out-of-range error.

Reset
REQ-021 Asserting rst SHALL immediately clear these outputs and state:
- rd_valid_o=0, rd_data_o=0, ready_o=0, init_done_o=0.
- The clear counter returns to 0 and all in-flight reads are discarded.
REQ-022 Reset asserted mid-CLEAR SHALL restart clearing from address 0 after deassertion.
REQ-023 Reset asserted in RUN SHALL discard pending reads; array contents are undefined only if CLEAR_ON_RESET=0.

Structure
REQ-024 A shared package dmem_pkg SHALL hold:
- the state enum (CLEAR, RUN);
- default width constants;
- a byte-merge function (old word, new word, mask -> merged word).
REQ-025 The storage array SHALL be one sub-module, dmem_array, a 1W1R masked synchronous array.
- It has no bypass logic.
- Forwarding, the FSM and the latency pipeline live in the top module.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- Clear: after reset, ready_o=0 for 256 cycles, then 1; read of addr 0x7F -> 0x00000000.
- Masked write: write 0xAABBCCDD to 0x10 with mask 0xF, then 0x11223344 with mask 0x5; read 0x10 -> 0xAA22CC44 one cycle after accept.
- Same-cycle bypass: array[0x20]=0x12345678; same-cycle write 0xFFFFFFFF mask 0x2 and read 0x20 -> 0x1234FF78.
- Latency 2: accept read 0x30 (array holds 0x1) at cycle N, then write 0x2 to 0x30 at N+1 -> rd_data_o=0x1 at N+2, a new read returns 0x2.
- Back-to-back: reads to 0..7 on consecutive cycles -> eight consecutive rd_valid_o pulses with data in order.
- Reset mid-clear: assert rst at clear cycle 100 -> ready_o stays 0 for a full 256 cycles after deassertion, and in-flight rd_valid_o drops immediately.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types, default widths and the byte-lane merge helper for the
// bypassing data-memory block.
package dmem_pkg;

    // Controller states: CLEAR sweeps zeros through the array, RUN serves requests
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 8;

    // The merge helper works on the widest word we support; callers
    // zero-extend their operands and truncate the result back down.
    localparam int MAX_DATA_WIDTH = 256;
    localparam int MAX_WMASKS     = MAX_DATA_WIDTH / 8;

    // Byte-wise merge: lanes with a set mask bit take new_w, the rest keep old_w
    function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_w,
        input logic [MAX_DATA_WIDTH-1:0] new_w,
        input logic [MAX_WMASKS-1:0]     mask
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_w;
        for (int k = 0; k < MAX_WMASKS; k++) begin
            if (mask[k]) begin
                merged[8*k +: 8] = new_w[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Plain 1W1R synchronous storage with per-byte write enables.
// A same-cycle read of the address being written returns the old word;
// the top level is responsible for forwarding.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [NUM_WMASKS-1:0] wmask_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Update only the byte lanes whose enable is set
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int k = 0; k < NUM_WMASKS; k++) begin
                if (wmask_i[k]) begin
                    r_mem[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Registered read; the output register only moves when a read is issued
    always_ff @(posedge clk) begin
        if (re_i) begin
            r_rdata <= r_mem[raddr_i];
        end
    end

    assign rdata_o = r_rdata;

endmodule

// File: rtl/dmem_bypass_ram.sv
// Data memory wrapper: clears the array after reset, accepts one read and
// one write per cycle, forwards same-cycle same-address writes byte by byte
// and delivers read data after a fixed 1- or 2-cycle latency.
module dmem_bypass_ram
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int NUM_WMASKS     = DATA_WIDTH / 8,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [NUM_WMASKS-1:0] wr_mask_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  ready_o,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  init_done_o
);

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic                  w_clr_last;

    logic                  w_ready;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    logic                  w_arr_we;
    logic [ADDR_WIDTH-1:0] w_arr_waddr;
    logic [NUM_WMASKS-1:0] w_arr_wmask;
    logic [DATA_WIDTH-1:0] w_arr_wdata;
    logic [DATA_WIDTH-1:0] w_arr_rdata;

    logic                  r_v1;
    logic                  r_byp_hit;
    logic [NUM_WMASKS-1:0] r_byp_mask;
    logic [DATA_WIDTH-1:0] r_byp_data;
    logic [NUM_WMASKS-1:0] w_byp_mask;
    logic [DATA_WIDTH-1:0] w_s1_data;

    logic                  w_out_valid;
    logic [DATA_WIDTH-1:0] w_out_data;
    logic [DATA_WIDTH-1:0] r_hold;

    assign w_clr_last = &r_clr_addr;
    assign w_wr_acc   = wr_en_i && w_ready;
    assign w_rd_acc   = rd_en_i && w_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: leave CLEAR once the last address has been zeroed
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CLEAR:   if (w_clr_last) w_next_state = RUN;
            RUN:     w_next_state = RUN;
            default: w_next_state = RESET_STATE;
        endcase
    end

    // State outputs: ready only in RUN (and never while reset is held);
    // during CLEAR the array write port is taken over by the sweep
    always_comb begin
        w_ready     = (r_state == RUN) && !rst;
        w_arr_we    = w_wr_acc;
        w_arr_waddr = wr_addr_i;
        w_arr_wmask = wr_mask_i;
        w_arr_wdata = wr_data_i;
        if (r_state == CLEAR) begin
            w_arr_we    = 1'b1;
            w_arr_waddr = r_clr_addr;
            w_arr_wmask = {NUM_WMASKS{1'b1}};
            w_arr_wdata = '0;
        end
    end

    // Sweep address for clearing; restarts at zero on every reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_addr <= '0;
        end else if (r_state == CLEAR) begin
            r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
        end
    end

    dmem_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .NUM_WMASKS(NUM_WMASKS)
    ) u_array (
        .clk     (clk),
        .we_i    (w_arr_we),
        .waddr_i (w_arr_waddr),
        .wmask_i (w_arr_wmask),
        .wdata_i (w_arr_wdata),
        .re_i    (w_rd_acc),
        .raddr_i (rd_addr_i),
        .rdata_o (w_arr_rdata)
    );

    // First read stage: remember whether the read collided with a write
    // in the same cycle, and which lanes that write touched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1       <= 1'b0;
            r_byp_hit  <= 1'b0;
            r_byp_mask <= '0;
            r_byp_data <= '0;
        end else begin
            r_v1       <= w_rd_acc;
            r_byp_hit  <= w_wr_acc && w_rd_acc && (wr_addr_i == rd_addr_i);
            r_byp_mask <= wr_mask_i;
            r_byp_data <= wr_data_i;
        end
    end

    assign w_byp_mask = r_byp_hit ? r_byp_mask : '0;
    assign w_s1_data  = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(w_arr_rdata),
                                               MAX_DATA_WIDTH'(r_byp_data),
                                               MAX_WMASKS'(w_byp_mask)));

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_v2;
            logic [DATA_WIDTH-1:0] r_d2;

            // Second stage snapshots the merged word so later writes cannot alter it
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v2 <= 1'b0;
                    r_d2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_d2 <= w_s1_data;
                    end
                end
            end

            assign w_out_valid = r_v2;
            assign w_out_data  = r_d2;
        end else begin : g_lat1
            assign w_out_valid = r_v1;
            assign w_out_data  = w_s1_data;
        end
    endgenerate

    // Keep the last delivered word so rd_data_o is stable between pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
        end else if (w_out_valid) begin
            r_hold <= w_out_data;
        end
    end

    assign ready_o     = w_ready;
    assign init_done_o = w_ready;
    assign rd_valid_o  = w_out_valid;
    assign rd_data_o   = w_out_valid ? w_out_data : r_hold;

endmodule

// File: tb/tb_dmem_bypass_ram.sv
// Directed self-checking bench for dmem_bypass_ram. Two instances share
// the same stimulus: dut1 with one cycle of read latency, dut2 with two.
module tb_dmem_bypass_ram;

    logic        clk;
    logic        rst;
    logic        wrEn;
    logic [7:0]  wrAddr;
    logic [3:0]  wrMask;
    logic [31:0] wrData;
    logic        rdEn;
    logic [7:0]  rdAddr;

    logic        ready1, valid1, init1;
    logic [31:0] data1;
    logic        ready2, valid2, init2;
    logic [31:0] data2;

    int checks = 0;
    int errors = 0;

    dmem_bypass_ram #(.READ_LATENCY(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (wrEn),
        .wr_addr_i   (wrAddr),
        .wr_mask_i   (wrMask),
        .wr_data_i   (wrData),
        .rd_en_i     (rdEn),
        .rd_addr_i   (rdAddr),
        .ready_o     (ready1),
        .rd_valid_o  (valid1),
        .rd_data_o   (data1),
        .init_done_o (init1)
    );

    dmem_bypass_ram #(.READ_LATENCY(2)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (wrEn),
        .wr_addr_i   (wrAddr),
        .wr_mask_i   (wrMask),
        .wr_data_i   (wrData),
        .rd_en_i     (rdEn),
        .rd_addr_i   (rdAddr),
        .ready_o     (ready2),
        .rd_valid_o  (valid2),
        .rd_data_o   (data2),
        .init_done_o (init2)
    );

    // Free-running 10-time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive every request input at once
    task automatic applyStimulus(input logic we, input logic [7:0] wa, input logic [3:0] wm,
                                 input logic [31:0] wd, input logic re, input logic [7:0] ra);
        wrEn   = we;
        wrAddr = wa;
        wrMask = wm;
        wrData = wd;
        rdEn   = re;
        rdAddr = ra;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count cycles until ready rises, bounded so a stuck design still finishes
    task automatic waitReady(input string tag, input int expCycles);
        int n;
        n = 0;
        while (ready1 !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(n), 32'(expCycles));
    endtask

    // Write one word and return with the request removed
    task automatic writeWord(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        applyStimulus(1'b1, a, m, d, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 8'h00);
    endtask

    // Directed sequence
    initial begin
        applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 8'h00);
        rst = 1'b1;
        #1;
        checkOutput("rst_ready",  {31'b0, ready1}, 32'h0);
        checkOutput("rst_init",   {31'b0, init1},  32'h0);
        checkOutput("rst_valid",  {31'b0, valid1}, 32'h0);
        checkOutput("rst_data",   data1,           32'h0);
        checkOutput("rst_ready2", {31'b0, ready2}, 32'h0);
        repeat (3) tick();
        rst = 1'b0;

        // Clearing takes one cycle per address
        waitReady("clear_cycles", 256);
        checkOutput("init_done", {31'b0, init1}, 32'h1);
        checkOutput("ready2",    {31'b0, ready2}, 32'h1);

        applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 8'h7F);
        tick();
        applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 8'h00);
        checkOutput("clr_rd_valid", {31'b0, valid1}, 32'h1);
        checkOutput("clr_rd_data",  data1, 32'h0);

        // Masked write: full word then lanes 0 and 2
        writeWord(8'h10, 32'hAABBCCDD, 4'hF);
        writeWord(8'h10, 32'h11223344, 4'h5);
        applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 8'h10);
        tick();
        applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 8'h00);
        checkOutput("mask_valid", {31'b0, valid1}, 32'h1);
        checkOutput("mask_data",  data1, 32'hAA22CC44);
        tick();
        checkOutput("hold_valid", {31'b0, valid1}, 32'h0);
        checkOutput("hold_data",  data1, 32'hAA22CC44);

        // Same-cycle write/read to one address forwards lane 1
        writeWord(8'h20, 32'h12345678, 4'hF);
        applyStimulus(1'b1, 8'h20, 4'h2, 32'hFFFFFFFF, 1'b1, 8'h20);
        tick();
        applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 8'h00);
        checkOutput("byp_data", data1, 32'h1234FF78);
        writeWord(8'h20, 32'hDEADBEEF, 4'h0);
        applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 8'h20);
        tick();
        applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 8'h00);
        checkOutput("mask0_data", data1, 32'h1234FF78);

        // Latency 2: a write right after the read accept does not leak in
        writeWord(8'h30, 32'h00000001, 4'hF);
        applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 8'h30);
        tick();
        applyStimulus(1'b1, 8'h30, 4'hF, 32'h00000002, 1'b0, 8'h00);
        checkOutput("lat1_data", data1, 32'h1);
        checkOutput("lat2_early", {31'b0, valid2}, 32'h0);
        tick();
        applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 8'h00);
        checkOutput("lat2_valid", {31'b0, valid2}, 32'h1);
        checkOutput("lat2_snap",  data2, 32'h1);
        applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 8'h30);
        tick();
        applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 8'h00);
        tick();
        checkOutput("lat2_new", data2, 32'h2);

        // Read and write to different addresses in the same cycle
        applyStimulus(1'b1, 8'h40, 4'hF, 32'hCAFEF00D, 1'b1, 8'h10);
        tick();
        applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 8'h40);
        checkOutput("rw_rd_data", data1, 32'hAA22CC44);
        tick();
        applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 8'h00);
        checkOutput("rw_wr_data", data1, 32'hCAFEF00D);
        tick();

        // Back-to-back reads of addresses 0..7
        for (int i = 0; i < 8; i++) begin
            writeWord(8'(i), 32'h100 + 32'(i), 4'hF);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 8'(i));
            tick();
            checkOutput($sformatf("b2b_valid%0d", i), {31'b0, valid1}, 32'h1);
            checkOutput($sformatf("b2b_data%0d", i), data1, 32'h100 + 32'(i));
            if (i > 0) begin
                checkOutput($sformatf("b2b_l2_data%0d", i - 1), data2, 32'h100 + 32'(i - 1));
            end
        end
        applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 8'h00);
        tick();
        checkOutput("b2b_end_valid", {31'b0, valid1}, 32'h0);
        checkOutput("b2b_l2_last",   data2, 32'h107);

        // Reset while a read is being delivered / still in flight
        applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 8'h10);
        tick();
        applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 8'h00);
        checkOutput("pre_rst_valid", {31'b0, valid1}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_valid", {31'b0, valid1}, 32'h0);
        checkOutput("async_data",  data1, 32'h0);
        checkOutput("async_ready", {31'b0, ready1}, 32'h0);
        tick();
        checkOutput("inflight_l2", {31'b0, valid2}, 32'h0);
        rst = 1'b0;

        // Reset at clear cycle 100 restarts the full sweep
        repeat (100) tick();
        checkOutput("mid_clear_ready", {31'b0, ready1}, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        waitReady("reclear_cycles", 256);

        applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 8'h10);
        tick();
        applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 8'h00);
        checkOutput("cleared_data", data1, 32'h0);
        tick();
        checkOutput("cleared_l2", data2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
